// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memctl port arbiter: FSM state encoding and the
// memctl data width.
package a3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int MEM_DW = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake plus memctl-side strobes of the arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if
  import a3_mem_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = 16,
  parameter int DW    = MEM_DW
);

  logic [N_REQ-1:0]    req_i;
  logic [N_REQ-1:0]    we_i;
  logic [N_REQ*AW-1:0] addr_i;
  logic [N_REQ*DW-1:0] wdata_i;
  logic [N_REQ-1:0]    ack_o;
  logic [DW-1:0]       rdata_o;
  logic [N_REQ-1:0]    grant_o;
  logic                busy_o;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       mem_wdata_o;
  logic                mem_write_en_o;
  logic                mem_read_en_o;
  logic [DW-1:0]       mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    output ack_o, rdata_o, grant_o, busy_o,
           mem_addr_o, mem_wdata_o, mem_write_en_o, mem_read_en_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    input  ack_o, rdata_o, grant_o, busy_o,
           mem_addr_o, mem_wdata_o, mem_write_en_o, mem_read_en_o
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from last+1,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!valid && req[(int'(last) + i) % N]) begin
        valid                      = 1'b1;
        idx                        = IW'((int'(last) + i) % N);
        gnt[(int'(last) + i) % N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single byte-wide memctl port between
// N_REQ requesters, one transaction at a time.
//
//   state | meaning
//   IDLE  | no owner; arbitrate and latch the winner's request
//   ISSUE | one-cycle memctl strobe (write_en or read_en)
//   WAIT  | read only: count out READ_LAT, then capture mem_rdata_i
//   DONE  | ack the owner, update last_grant, release the port
module mem_arbiter
  import a3_mem_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int AW       = 16,
  parameter int DW       = MEM_DW,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(READ_LAT + 1);

  arb_state_t       state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    idx;
  logic             we_lat;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] grant;
  logic [DW-1:0]    rdata;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_write_en;
  logic             mem_read_en;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (bus.req_i),
    .last  (last_grant),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // One-hot mux of the winner's request fields
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_we    = bus.we_i[k];
        sel_addr  = bus.addr_i[k*AW +: AW];
        sel_wdata = bus.wdata_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= IW'(N_REQ - 1);
      idx          <= '0;
      we_lat       <= 1'b0;
      cnt          <= '0;
      grant        <= '0;
      rdata        <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx          <= pick_idx;
            grant        <= pick_gnt;
            we_lat       <= sel_we;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            mem_write_en <= sel_we;
            mem_read_en  <= !sel_we;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          mem_write_en <= 1'b0;
          mem_read_en  <= 1'b0;
          if (we_lat) begin
            state <= DONE;
          end else begin
            cnt   <= CW'(READ_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rdata <= bus.mem_rdata_i;
            state <= DONE;
          end
        end
        DONE: begin
          last_grant <= idx;
          grant      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_o          = (state == DONE) ? grant : '0;
  assign bus.grant_o        = grant;
  assign bus.busy_o         = (state != IDLE);
  assign bus.rdata_o        = rdata;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;
  assign bus.mem_write_en_o = mem_write_en;
  assign bus.mem_read_en_o  = mem_read_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte memory model.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  mem_arbiter_if #(.N_REQ(2), .AW(16), .DW(8)) bus ();

  mem_arbiter #(.N_REQ(2), .AW(16), .DW(8), .READ_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte array on the low address byte, read data one cycle later
  logic [7:0]  mem [256];
  int          wr_cnt;
  logic [15:0] last_wr_addr;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10]      <= 8'h5C;
      wr_cnt          <= 0;
      last_wr_addr    <= 16'h0;
      bus.mem_rdata_i <= 8'h00;
    end else begin
      if (bus.mem_write_en_o) begin
        mem[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
        wr_cnt                   <= wr_cnt + 1;
        last_wr_addr             <= bus.mem_addr_o;
      end
      if (bus.mem_read_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o[7:0]];
    end
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic [1:0] exp, input string tag);
    int n;
    n = 0;
    while (bus.ack_o == 2'b00 && n < 12) begin
      chk("no_overlap", {63'd0, bus.mem_write_en_o & bus.mem_read_en_o}, 64'd0);
      step();
      n++;
    end
    chk(tag, {62'd0, bus.ack_o}, {62'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset       = 1'b0;
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    // Reset and idle
    repeat (3) step();
    chk("in_reset", {25'd0, bus.ack_o, bus.grant_o, bus.busy_o, bus.mem_write_en_o,
        bus.mem_read_en_o, bus.rdata_o, bus.mem_addr_o, bus.mem_wdata_o}, 64'd0);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle", {25'd0, bus.ack_o, bus.grant_o, bus.busy_o, bus.mem_write_en_o,
          bus.mem_read_en_o, bus.rdata_o, bus.mem_addr_o, bus.mem_wdata_o}, 64'd0);
    end

    // Single write from requester 0
    bus.req_i = 2'b01;
    bus.we_i  = 2'b01;
    bus.addr_i[0 +: 16] = 16'h1234;
    bus.wdata_i[0 +: 8] = 8'hA5;
    step();
    chk("wr_strobe", {63'd0, bus.mem_write_en_o}, 64'd1);
    chk("wr_no_rd", {63'd0, bus.mem_read_en_o}, 64'd0);
    chk("wr_addr", {48'd0, bus.mem_addr_o}, 64'h1234);
    chk("wr_data", {56'd0, bus.mem_wdata_o}, 64'hA5);
    chk("wr_grant", {62'd0, bus.grant_o}, 64'd1);
    chk("wr_ack_early", {62'd0, bus.ack_o}, 64'd0);
    step();
    chk("wr_ack", {62'd0, bus.ack_o}, 64'd1);
    chk("wr_strobe_off", {63'd0, bus.mem_write_en_o}, 64'd0);
    chk("wr_mem", {56'd0, mem[8'h34]}, 64'hA5);
    bus.req_i = 2'b00;
    step();
    chk("wr_after", {59'd0, bus.ack_o, bus.grant_o, bus.busy_o}, 64'd0);

    // Single read from requester 1
    bus.req_i = 2'b10;
    bus.we_i  = 2'b00;
    bus.addr_i[16 +: 16] = 16'h0010;
    step();
    chk("rd_strobe", {62'd0, bus.mem_read_en_o, bus.mem_write_en_o}, 64'b10);
    chk("rd_grant", {62'd0, bus.grant_o}, 64'b10);
    chk("rd_addr", {48'd0, bus.mem_addr_o}, 64'h0010);
    step();
    chk("rd_wait", {60'd0, bus.mem_read_en_o, bus.busy_o, bus.ack_o}, 64'b0100);
    step();
    chk("rd_ack", {62'd0, bus.ack_o}, 64'b10);
    chk("rd_data", {56'd0, bus.rdata_o}, 64'h5C);
    bus.req_i = 2'b00;
    step();
    chk("rd_hold", {54'd0, bus.ack_o, bus.rdata_o}, 64'h5C);

    // Contention: both requesters write continuously
    base = wr_cnt;
    bus.we_i = 2'b11;
    bus.addr_i[0 +: 16]  = 16'h0020;
    bus.addr_i[16 +: 16] = 16'h0021;
    bus.wdata_i[0 +: 8]  = 8'h11;
    bus.wdata_i[8 +: 8]  = 8'h22;
    bus.req_i = 2'b11;
    step();
    wait_ack(2'b01, "rr_0");
    step();
    wait_ack(2'b10, "rr_1");
    step();
    wait_ack(2'b01, "rr_2");
    step();
    wait_ack(2'b10, "rr_3");
    bus.req_i = 2'b00;
    step();
    chk("rr_wr_cnt", 64'(wr_cnt - base), 64'd4);
    chk("rr_mem0", {56'd0, mem[8'h20]}, 64'h11);
    chk("rr_mem1", {56'd0, mem[8'h21]}, 64'h22);

    // Inputs changed and request dropped after grant
    bus.we_i = 2'b01;
    bus.addr_i[0 +: 16] = 16'h0001;
    bus.wdata_i[0 +: 8] = 8'h3C;
    bus.req_i = 2'b01;
    step();
    chk("late_grant", {62'd0, bus.grant_o}, 64'b01);
    bus.addr_i[0 +: 16] = 16'h00FF;
    bus.wdata_i[0 +: 8] = 8'hFF;
    bus.req_i = 2'b00;
    step();
    chk("late_ack", {62'd0, bus.ack_o}, 64'b01);
    chk("late_addr", {48'd0, last_wr_addr}, 64'h0001);
    chk("late_mem", {56'd0, mem[8'h01]}, 64'h3C);
    chk("late_mem_ff", {56'd0, mem[8'hFF]}, 64'h00);
    step();
    chk("late_idle", {63'd0, bus.busy_o}, 64'd0);

    // Reset during WAIT of a read by requester 1 (last_grant is 0)
    bus.we_i = 2'b00;
    bus.addr_i[0 +: 16]  = 16'h0010;
    bus.addr_i[16 +: 16] = 16'h0010;
    bus.req_i = 2'b11;
    step();
    chk("rst_pre_grant", {62'd0, bus.grant_o}, 64'b10);
    step();
    chk("rst_in_wait", {63'd0, bus.busy_o}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_cut", {59'd0, bus.mem_read_en_o, bus.ack_o, bus.grant_o}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("rst_prio0", {62'd0, bus.grant_o}, 64'b01);
    chk("rst_prio0_rd", {63'd0, bus.mem_read_en_o}, 64'd1);

    // Reset during ISSUE cuts the read strobe at once
    reset = 1'b0;
    #1;
    chk("rst_issue_cut", {63'd0, bus.mem_read_en_o}, 64'd0);
    #1;
    reset = 1'b1;
    bus.req_i = 2'b01;
    step();
    chk("rst2_grant", {62'd0, bus.grant_o}, 64'b01);
    step();
    chk("rst2_wait_ack", {62'd0, bus.ack_o}, 64'd0);
    step();
    chk("rst2_ack", {62'd0, bus.ack_o}, 64'b01);
    chk("rst2_data", {56'd0, bus.rdata_o}, 64'h5C);
    bus.req_i = 2'b00;
    step();
    chk("final_idle", {59'd0, bus.ack_o, bus.grant_o, bus.busy_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memctl byte-wide memory port between N_REQ requesters, e.g. several CPU domains on the SoC.
- Each requester issues read or write transactions through a req/ack handshake.
- The arbiter grants one requester at a time in round-robin order, drives memctl's write_en/read_en/addr_in/data_in, and waits out the memory read latency.
- It returns read data to the granted requester only.

Parameters:
- N_REQ, 2: number of requesters; must be at least 2.
- AW, 16: memory address width.
- DW, 8: data width; matches memctl.
- READ_LAT, 1: cycles from mem_read_en high to valid mem_rdata; must be at least 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  per-requester transaction request; held high until ack.
- we_i  in  N_REQ  per-requester op select: 1 = write, 0 = read.
- addr_i  in  N_REQ*AW  flattened addresses; requester k occupies [k*AW +: AW].
- wdata_i  in  N_REQ*DW  flattened write data; requester k occupies [k*DW +: DW].
- ack_o  out  N_REQ  one-cycle completion pulse, one-hot.
- rdata_o  out  DW  read data; valid in the ack_o cycle of a read.
- grant_o  out  N_REQ  one-hot current owner; 0 when idle.
- busy_o  out  1  high in every state except IDLE.
- mem_addr_o  out  AW  connects to memctl addr_in.
- mem_wdata_o  out  DW  connects to memctl data_in.
- mem_write_en_o  out  1  connects to memctl write_en.
- mem_read_en_o  out  1  connects to memctl read_en.
- mem_rdata_i  in  DW  connects to memctl data_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - ack_o, grant_o, busy_o, mem_write_en_o and mem_read_en_o go to 0.
  - rdata_o, mem_addr_o and mem_wdata_o go to 0.
  - last_grant goes to N_REQ-1, so requester 0 has first priority.
  - Wait counter goes to 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req_i is nonzero, pick the first set bit searching upward from last_grant+1, modulo N_REQ.
  - Register the winner's index, we, addr and wdata.
  - Set grant_o to the winner's one-hot value and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_addr_o and mem_wdata_o drive the latched values.
  - A write pulses mem_write_en_o, then goes to DONE.
  - A read pulses mem_read_en_o, loads the counter with READ_LAT-1, then goes to WAIT.
  - write_en and read_en are never high together.
  - Both are 0 in every other state.
- WAIT:
  - While the counter is nonzero, decrement it.
  - When it is 0, capture mem_rdata_i into rdata_o and go to DONE.
  - With READ_LAT=1, WAIT lasts one cycle.
- DONE:
  - ack_o[idx]=1 for this cycle only.
  - Update last_grant to idx, clear grant_o and go to IDLE.
  - rdata_o holds its value until the next read capture.
- Latency from the req_i sample in IDLE to ack_o:
  - Write: 2 cycles, i.e. ack appears in the third cycle.
  - Read: 2 + READ_LAT cycles.
- A new grant is possible in the cycle after DONE.
- Request inputs are sampled only at grant.
  - Changes to we/addr/wdata after grant are ignored.
  - Dropping req_i mid-transaction does not abort it; the transaction completes and ack is still pulsed.
- A requester holding req_i high after ack is re-arbitrated on equal terms.
  - Round robin guarantees any other pending requester is served before it repeats.
  - With all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0,...
- Requests arriving in a non-IDLE state wait; nothing is dropped.
- Reset mid-transaction:
  - An in-flight memctl strobe is cut to 0 immediately.
  - No ack is produced for the interrupted transaction.
  - A write in progress may or may not have completed in memory; requesters must retry after reset.
- Address and data are passed unmodified; there is no width arithmetic beyond the counter.
- The counter is $clog2(READ_LAT+1) bits wide.

Decomposition:
- Package a3_mem_pkg holds:
  - the typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT, DONE};
  - localparam MEM_DW = 8, the memctl data width shared with memctl.
- Sub-module rr_pick (combinational, parameter N) takes req[N-1:0] and last[$clog2(N)-1:0].
  - Outputs are a one-hot gnt, an index idx and a valid flag.
  - It is instantiated once in mem_arbiter.
- mem_arbiter holds the FSM, latches and counter.

Test Plan:
- Reset: hold reset=0, then release with no requests → all outputs 0, busy_o=0, and mem strobes 0 for 20 cycles.
- Single write: req_i=01, we_i=01, addr0=0x1234, wdata0=0xA5 → mem_write_en_o=1 with mem_addr_o=0x1234 and mem_wdata_o=0xA5 for exactly one cycle; ack_o=01 two cycles after IDLE sampled req.
- Single read: with READ_LAT=1 and the memory model returning 0x5C for 0x0010, req_i=10, we_i=00, addr1=0x0010 → mem_read_en_o one cycle, then ack_o=10 and rdata_o=0x5C at cycle 3.
- Contention: req_i=11 held for 4 transactions → grant order 0,1,0,1, one-hot ack each, and no overlapping strobes.
- Late input change: after the grant of a write to 0x0001, change addr0 to 0x00FF and drop req_i → memory write still targets 0x0001 and ack_o is still pulsed.
- Reset mid-read: assert reset during WAIT → mem_read_en_o and ack_o are 0 immediately; after release, requester 0 has priority again with last_grant=N_REQ-1.
